// File: rtl/ks_adder_pipe.sv
// ============================================================================
// Module      : ks_adder_pipe
// Description : Kogge-Stone adder/subtractor with optional per-level pipeline
//               registers and a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ks_adder_pipe #(
    parameter int WIDTH    = 8,
    parameter int PIPELINE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int LEVELS = $clog2(WIDTH);
    // Index 0 of the extended vectors is the carry-in, bit i sits at index i+1.
    localparam int N      = WIDTH + 1;

    typedef struct packed {
        logic [WIDTH-1:0] p;
        logic             a_msb;
        logic             bp_msb;
        logic [N-1:0]     g;
        logic [N-1:0]     pg;
    } stage_t;

    function automatic stage_t f_level(input stage_t s, input int k);
        stage_t o;
        int     d;
        o = s;
        d = 1 << k;
        for (int i = d; i < N; i++) begin
            o.g[i]  = s.g[i] | (s.pg[i] & s.g[i-d]);
            o.pg[i] = s.pg[i] & s.pg[i-d];
        end
        return o;
    endfunction

    logic             w_adv;
    logic [WIDTH-1:0] w_bp;
    logic             w_c0;
    stage_t           w_prep;
    stage_t           w_final;
    logic             w_final_vld;
    logic             w_unused_pg;

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;
    logic             ovf_d, ovf_q;
    logic             zero_d, zero_q;
    logic             out_valid_d, out_valid_q;

    assign w_adv    = ~out_valid_q | out_ready;
    assign in_ready = w_adv;

    always_comb begin
        w_bp          = sub ? ~b : b;
        w_c0          = sub ? ~cin : cin;
        w_prep.p      = a ^ w_bp;
        w_prep.a_msb  = a[WIDTH-1];
        w_prep.bp_msb = w_bp[WIDTH-1];
        w_prep.g      = {a & w_bp, w_c0};
        w_prep.pg     = {a ^ w_bp, 1'b0};
    end

    generate
        if (PIPELINE != 0) begin : g_pipe
            stage_t            stg_d [LEVELS];
            stage_t            stg_q [LEVELS];
            logic [LEVELS-1:0] vld_d, vld_q;

            // Stage 0 holds the p/g vectors; stage k holds the result of level k-1.
            always_comb begin
                for (int k = 0; k < LEVELS; k++) begin
                    stg_d[k] = stg_q[k];
                end
                vld_d = vld_q;
                if (w_adv) begin
                    stg_d[0] = w_prep;
                    vld_d[0] = in_valid;
                    for (int k = 1; k < LEVELS; k++) begin
                        stg_d[k] = f_level(stg_q[k-1], k-1);
                        vld_d[k] = vld_q[k-1];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < LEVELS; k++) begin
                        stg_q[k] <= '0;
                    end
                    vld_q <= '0;
                end else begin
                    for (int k = 0; k < LEVELS; k++) begin
                        stg_q[k] <= stg_d[k];
                    end
                    vld_q <= vld_d;
                end
            end

            assign w_final     = f_level(stg_q[LEVELS-1], LEVELS-1);
            assign w_final_vld = vld_q[LEVELS-1];
        end else begin : g_comb
            always_comb begin
                stage_t v;
                v = w_prep;
                for (int k = 0; k < LEVELS; k++) begin
                    v = f_level(v, k);
                end
                w_final = v;
            end

            assign w_final_vld = in_valid;
        end
    endgenerate

    // Only the top group-propagate is needed: it recovers cout when the prefix
    // span stops one short of the carry-in (WIDTH a power of two).
    assign w_unused_pg = ^w_final.pg[N-2:0];

    always_comb begin
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        if (w_adv) begin
            out_valid_d = w_final_vld;
            sum_d       = w_final.p ^ w_final.g[WIDTH-1:0];
            cout_d      = w_final.g[N-1] | (w_final.pg[N-1] & w_final.g[0]);
            ovf_d       = (w_final.a_msb == w_final.bp_msb) & (sum_d[WIDTH-1] != w_final.a_msb);
            zero_d      = ~|sum_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign out_valid = out_valid_q;

endmodule

`default_nettype wire
